// File: rtl/mul_div_unit.sv
// ============================================================================
// Module  : mul_div_unit
// Brief   : Multi-cycle multiply/divide unit owning the architectural HI/LO
//           registers. Optional multiply-accumulate ops enabled by MDU_MADD_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    function automatic logic is_mul_op(input logic [3:0] o);
`ifdef MDU_MADD_EN
        return o inside {OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
`else
        return o inside {OP_MULT, OP_MULTU};
`endif
    endfunction

    function automatic logic is_div_op(input logic [3:0] o);
        return o inside {OP_DIV, OP_DIVU};
    endfunction

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   count, target;
    logic [3:0]         op_q;
    logic [31:0]        a_q, b_q;
    logic               last, accept, new_multi, new_mthi, new_mtlo, write_hilo;

    // Accepting on the final RUN cycle lets a stalled instruction issue back-to-back.
    always_comb begin
        state_nxt = state;
        target    = is_div_op(op_q) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
        last      = (state == RUN) && (count == target);
        accept    = start && ((state == IDLE) || last);
        new_multi = accept && (is_mul_op(op) || is_div_op(op));
        new_mthi  = accept && (op == OP_MTHI);
        new_mtlo  = accept && (op == OP_MTLO);
        case (state)
            IDLE:    if (new_multi) state_nxt = RUN;
            RUN:     if (last)      state_nxt = new_multi ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == RUN);

    logic        signed_op, a_neg, b_neg;
    logic [63:0] a_ext, b_ext, product, result;
    logic [31:0] a_mag, b_mag, divisor, q_mag, r_mag, quo, rem;

    always_comb begin
`ifdef MDU_MADD_EN
        signed_op = op_q inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
`else
        signed_op = op_q inside {OP_MULT, OP_DIV};
`endif
        a_ext   = {{32{signed_op & a_q[31]}}, a_q};
        b_ext   = {{32{signed_op & b_q[31]}}, b_q};
        product = a_ext * b_ext;

        // Divide on magnitudes so INT_MIN / -1 wraps cleanly to INT_MIN.
        a_neg   = signed_op & a_q[31];
        b_neg   = signed_op & b_q[31];
        a_mag   = a_neg ? -a_q : a_q;
        b_mag   = b_neg ? -b_q : b_q;
        divisor = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag   = a_mag / divisor;
        r_mag   = a_mag % divisor;
        quo     = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem     = a_neg ? -r_mag : r_mag;

        case (op_q)
            OP_DIV, OP_DIVU:   result = {rem, quo};
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU: result = {hi, lo} + product;
            OP_MSUB, OP_MSUBU: result = {hi, lo} - product;
`endif
            default:           result = product;
        endcase

        write_hilo = last && !(is_div_op(op_q) && (b_q == 32'd0));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            count <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            done  <= 1'b0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            done  <= last;
            if (new_multi) begin
                op_q  <= op;
                a_q   <= rs_data;
                b_q   <= rt_data;
                count <= CNT_W'(1);
            end else if (last) begin
                count <= '0;
            end else if (state == RUN) begin
                count <= count + CNT_W'(1);
            end
            if (write_hilo) begin
                hi <= result[63:32];
                lo <= result[31:0];
            end
            // A move issued on the commit edge is the younger instruction and wins.
            if (new_mthi) hi <= rs_data;
            if (new_mtlo) lo <= rs_data;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_div_unit.sv
// ============================================================================
// Module  : tb_mul_div_unit
// Brief   : Scoreboard-driven self-checking bench for mul_div_unit.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_div_unit;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk, reset, start;
    logic [3:0]  op;
    logic [31:0] rs_data, rt_data;
    logic        busy, done;
    logic [31:0] hi, lo;

    int vectors     = 0;
    int miscompares = 0;
    logic [63:0] sb[$];

    mul_div_unit #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .rs_data(rs_data), .rt_data(rt_data),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive one op for a single edge, then scramble operands to prove they were latched.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0; op = 4'($urandom); rs_data = $urandom; rt_data = $urandom;
    endtask

    task automatic wait_idle(input int bound, output int cycles, output bit changed);
        logic [63:0] snap;
        snap = {hi, lo};
        cycles = 0;
        changed = 1'b0;
        while (busy === 1'b1 && cycles < bound) begin
            if ({hi, lo} !== snap) changed = 1'b1;
            cycles++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        bit seen_done;
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL reset_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL reset_lo got %h want 0", lo); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", done); end
        @(negedge clk); reset = 1'b0;
        issue(4'd5, 32'hAAAA, 32'd0);
        issue(4'd6, 32'hBBBB, 32'd0);
        issue(4'd1, 32'd3, 32'd4);
        @(posedge clk); #2;
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL midop_busy got %b want 1", busy); end
        reset = 1'b1;
        #1;
        vectors++; if (hi !== 32'd0) begin miscompares++; $display("FAIL async_hi got %h want 0", hi); end
        vectors++; if (lo !== 32'd0) begin miscompares++; $display("FAIL async_lo got %h want 0", lo); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL async_busy got %b want 0", busy); end
        @(negedge clk); reset = 1'b0;
        seen_done = 1'b0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen_done = 1'b1;
        end
        vectors++; if (seen_done !== 1'b0) begin miscompares++; $display("FAIL post_reset_done got 1 want 0"); end
        vectors++; if ({hi, lo} !== 64'd0) begin miscompares++; $display("FAIL post_reset_hilo got %h want 0", {hi, lo}); end
    endtask

    task automatic run_mult(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [63:0] expect_hl, input int n, input string name);
        int cyc; bit chg; logic [63:0] exp_v;
        issue(o, a, b);
        sb.push_back(expect_hl);
        wait_idle(n + 4, cyc, chg);
        vectors++; if (cyc != n) begin miscompares++; $display("FAIL %s_busy_cycles got %0d want %0d", name, cyc, n); end
        vectors++; if (chg !== 1'b0) begin miscompares++; $display("FAIL %s_partial got changed want stable", name); end
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL %s_done got %b want 1", name, done); end
        exp_v = sb.pop_front();
        vectors++; if ({hi, lo} !== exp_v) begin miscompares++; $display("FAIL %s_result got %h want %h", name, {hi, lo}, exp_v); end
        @(posedge clk); #1;
        vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL %s_done_pulse got %b want 0", name, done); end
    endtask

    task automatic test_mult();
        run_mult(4'd1, 32'hFFFFFFFE, 32'd3, 64'hFFFFFFFF_FFFFFFFA, MULT_N, "mult");
        run_mult(4'd2, 32'hFFFFFFFE, 32'd3, 64'h00000002_FFFFFFFA, MULT_N, "multu");
        run_mult(4'd1, 32'h80000000, 32'h80000000, 64'h40000000_00000000, MULT_N, "mult_min");
    endtask

    task automatic test_div();
        run_mult(4'd3, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, DIV_N, "div_neg");
        run_mult(4'd3, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, DIV_N, "div_negdivisor");
        run_mult(4'd3, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, DIV_N, "div_ovf");
        run_mult(4'd4, 32'd100, 32'd7, 64'h00000002_0000000E, DIV_N, "divu");
        issue(4'd5, 32'h11, 32'd0);
        issue(4'd6, 32'h22, 32'd0);
        run_mult(4'd4, 32'd7, 32'd0, 64'h00000011_00000022, DIV_N, "divu_zero");
    endtask

    task automatic test_mthi_mtlo();
        bit any_busy; int cyc; bit chg;
        @(negedge clk); start = 1'b1; op = 4'd5; rs_data = 32'h1234;
        @(posedge clk); #1; any_busy = busy;
        @(negedge clk); op = 4'd6; rs_data = 32'h5678;
        @(posedge clk); #1; any_busy |= busy; start = 1'b0;
        @(posedge clk); #1; any_busy |= busy;
        vectors++; if (any_busy !== 1'b0) begin miscompares++; $display("FAIL mt_busy got 1 want 0"); end
        vectors++; if (hi !== 32'h1234) begin miscompares++; $display("FAIL mthi got %h want 00001234", hi); end
        vectors++; if (lo !== 32'h5678) begin miscompares++; $display("FAIL mtlo got %h want 00005678", lo); end
        // Divide by zero leaves HI alone, so an accepted MTHI would be visible.
        issue(4'd4, 32'd5, 32'd0);
        issue(4'd5, 32'hDEAD, 32'd0);
        wait_idle(DIV_N + 4, cyc, chg);
        vectors++; if (cyc + 1 != DIV_N) begin miscompares++; $display("FAIL mt_busy_len got %0d want %0d", cyc + 1, DIV_N); end
        vectors++; if (hi !== 32'h1234) begin miscompares++; $display("FAIL mthi_while_busy got %h want 00001234", hi); end
    endtask

    task automatic test_madd();
        bit any_busy;
        issue(4'd5, 32'd0, 32'd0);
        issue(4'd6, 32'hFFFFFFFF, 32'd0);
`ifdef MDU_MADD_EN
        run_mult(4'd8, 32'd1, 32'd1, 64'h00000001_00000000, MULT_N, "maddu");
        run_mult(4'd9, 32'd2, 32'hFFFFFFFF, 64'h00000001_00000002, MULT_N, "msub");
`else
        issue(4'd8, 32'd1, 32'd1);
        any_busy = busy;
        repeat (6) begin @(posedge clk); #1; any_busy |= busy; end
        vectors++; if (any_busy !== 1'b0) begin miscompares++; $display("FAIL maddu_off_busy got 1 want 0"); end
        vectors++; if ({hi, lo} !== 64'h00000000_FFFFFFFF) begin miscompares++; $display("FAIL maddu_off_hilo got %h want 00000000ffffffff", {hi, lo}); end
`endif
        issue(4'd15, 32'd9, 32'd9);
        any_busy = busy;
        repeat (3) begin @(posedge clk); #1; any_busy |= busy; end
        vectors++; if (any_busy !== 1'b0) begin miscompares++; $display("FAIL undef_op_busy got 1 want 0"); end
    endtask

    task automatic test_back_to_back();
        int cyc; bit chg; logic [63:0] exp_v;
        issue(4'd1, 32'd7, 32'd6);
        sb.push_back(64'h00000000_0000002A);
        repeat (MULT_N - 1) begin @(posedge clk); #1; end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_last_busy got %b want 1", busy); end
        issue(4'd3, 32'd100, 32'hFFFFFFFD);
        sb.push_back(64'h00000001_FFFFFFDF);
        vectors++; if (done !== 1'b1) begin miscompares++; $display("FAIL b2b_mult_done got %b want 1", done); end
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL b2b_div_busy got %b want 1", busy); end
        exp_v = sb.pop_front();
        vectors++; if ({hi, lo} !== exp_v) begin miscompares++; $display("FAIL b2b_mult_result got %h want %h", {hi, lo}, exp_v); end
        wait_idle(DIV_N + 4, cyc, chg);
        vectors++; if (cyc != DIV_N) begin miscompares++; $display("FAIL b2b_div_cycles got %0d want %0d", cyc, DIV_N); end
        exp_v = sb.pop_front();
        vectors++; if ({hi, lo} !== exp_v) begin miscompares++; $display("FAIL b2b_div_result got %h want %h", {hi, lo}, exp_v); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 4'd0; rs_data = 32'd0; rt_data = 32'd0;
        #12;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_madd();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout got running want finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
